fifo_rd_checker: RTL and testbench
==================================

FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 3: FIFO data word width.
REQ-002 SHALL have parameter PRESCALE_W, default 24: read-pacing prescaler width; one tick per 2^PRESCALE_W clocks.
REQ-003 SHALL have parameter ERR_W, default 8: error counter width.
REQ-004 SHALL have port clk_in, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_chk, input, 1: run/stop for the checker.
REQ-007 SHALL have port data_in, input, DATA_W: FIFO read data.
REQ-008 SHALL have port f_empty, input, 1: FIFO empty flag.
REQ-009 SHALL have port enable_rd, output, 1: registered FIFO read request, one-cycle pulse.
REQ-010 SHALL have port expected, output, DATA_W: next expected word.
REQ-011 SHALL have port err_count, output, ERR_W: mismatch count, saturating.
REQ-012 SHALL have port rd_count, output, 8: words checked, wraps modulo 256.
REQ-013 SHALL have port err_flag, output, 1: sticky mismatch indicator.
REQ-014 SHALL have port state, output, 2: current FSM state, for LED display.

Function
REQ-015 SHALL implement the states IDLE=00, WAIT=01, READ=10 and CHECK=11.
REQ-016 Prescaler SHALL count up in every state except IDLE, SHALL be cleared in IDLE, and SHALL assert tick for one cycle when it is all-ones.
REQ-017 IDLE SHALL go to WAIT when enable_chk=1 and SHALL set the sync flag (next word is a resync).
REQ-018 WAIT SHALL go to IDLE when enable_chk=0, else SHALL go to READ when tick=1 and f_empty=0, else SHALL stay in WAIT.
REQ-019 When tick=1 and f_empty=1 in WAIT, the FSM SHALL stay in WAIT and the read SHALL be deferred to the next tick; no read SHALL be issued while empty.
REQ-020 enable_rd SHALL be 1 exactly in the cycles where state=READ and 0 otherwise; READ SHALL always go to CHECK after one cycle.
REQ-021 CHECK SHALL sample data_in, which is valid the cycle after enable_rd, i.e. read latency is 1 clock.
REQ-022 In CHECK with sync flag=1: expected SHALL become data_in+1, no error SHALL be counted, and the sync flag SHALL be cleared.
REQ-023 In CHECK with sync flag=0 and data_in==expected: expected SHALL become expected+1.
REQ-024 In CHECK with sync flag=0 and data_in!=expected: err_count SHALL increment, err_flag SHALL be set, and expected SHALL become data_in+1 (resync).
REQ-025 All expected arithmetic SHALL be modulo 2^DATA_W; the all-ones to zero wrap SHALL be a match, not an error.
REQ-026 err_count SHALL saturate at all-ones and SHALL not wrap.
REQ-027 rd_count SHALL increment once per CHECK cycle, including resync words.
REQ-028 CHECK SHALL go to WAIT when enable_chk=1, else to IDLE.
REQ-029 If enable_chk drops during READ, the READ->CHECK sequence SHALL complete first, so the issued read is always checked.
REQ-030 err_flag, err_count and rd_count SHALL be cleared only by reset and SHALL not be cleared by enable_chk toggling.

Reset
REQ-031 While reset_n=0, regardless of clock: state SHALL be IDLE, enable_rd=0, expected=0, err_count=0, rd_count=0, err_flag=0, prescaler=0, sync flag=1.
REQ-032 Reset asserted mid-READ SHALL drop enable_rd immediately (asynchronously) and no CHECK SHALL follow.
REQ-033 Reset deassertion SHALL be synchronised in use: the first transition out of IDLE SHALL occur no earlier than the second rising edge after reset_n rises.

Verification
REQ-034 PRESCALE_W=2, FIFO model preloaded 0..7 then 0..3, enable_chk=1 -> 12 enable_rd pulses, each 4 clocks apart; rd_count=12; err_count=0; expected=4.
REQ-035 Sequence 5,6,0,1 -> first word is a resync (no error); word 0 counts err_count=1, err_flag=1; word 1 is a match; final expected=2.
REQ-036 f_empty=1 held for 3 ticks, then data 2 written -> no enable_rd while empty; exactly one read on the first tick after f_empty falls.
REQ-037 Force 300 mismatches with ERR_W=8 -> err_count=255 stays; rd_count wraps to 44; err_flag=1.
REQ-038 enable_chk=0 during READ -> one enable_rd, then CHECK, then IDLE; re-enable, next word resyncs with no error.
REQ-039 reset_n pulse low during READ -> enable_rd=0 within the same cycle; all outputs return to the REQ-031 values.

Source files
------------

// File: rtl/fifo_rd_checker.sv
// Paced FIFO reader that checks the read stream is an incrementing sequence.
// Counts mismatches (saturating), words checked, and keeps a sticky error flag.
//
// state  | meaning
// IDLE   | stopped, prescaler cleared, next word will resync
// WAIT   | waiting for a prescaler tick with the FIFO non-empty
// READ   | enable_rd asserted for one cycle
// CHECK  | compare the returned word against expected
module fifo_rd_checker #(
    parameter int DATA_W     = 3,
    parameter int PRESCALE_W = 24,
    parameter int ERR_W      = 8
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              enable_chk,
    input  logic [DATA_W-1:0] data_in,
    input  logic              f_empty,
    output logic              enable_rd,
    output logic [DATA_W-1:0] expected,
    output logic [ERR_W-1:0]  err_count,
    output logic [7:0]        rd_count,
    output logic              err_flag,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READ  = 2'b10,
        ST_CHECK = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                sync_q, sync_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [7:0]          rd_count_q, rd_count_d;
    logic                err_flag_q, err_flag_d;
    logic                enable_rd_q, enable_rd_d;
    logic                tick;
    logic                run;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prescale_q  <= '0;
            rst_sync_q  <= '0;
            sync_q      <= 1'b1;
            expected_q  <= '0;
            err_count_q <= '0;
            rd_count_q  <= '0;
            err_flag_q  <= 1'b0;
            enable_rd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescale_q  <= prescale_d;
            rst_sync_q  <= rst_sync_d;
            sync_q      <= sync_d;
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            rd_count_q  <= rd_count_d;
            err_flag_q  <= err_flag_d;
            enable_rd_q <= enable_rd_d;
        end
    end

    // Leaving IDLE waits for the two-stage reset release to propagate.
    assign run  = rst_sync_q[1];
    assign tick = &prescale_q;

    always_comb begin
        state_d     = state_q;
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        sync_d      = sync_q;
        expected_d  = expected_q;
        err_count_d = err_count_q;
        rd_count_d  = rd_count_q;
        err_flag_d  = err_flag_q;
        prescale_d  = (state_q == ST_IDLE) ? '0 : prescale_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (run && enable_chk) begin
                    state_d = ST_WAIT;
                    sync_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable_chk) begin
                    state_d = ST_IDLE;
                end else if (tick && !f_empty) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                rd_count_d = rd_count_q + 8'd1;
                if (sync_q) begin
                    expected_d = data_in + 1'b1;
                    sync_d     = 1'b0;
                end else if (data_in == expected_q) begin
                    expected_d = expected_q + 1'b1;
                end else begin
                    expected_d = data_in + 1'b1;
                    err_flag_d = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
                state_d = enable_chk ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the pulse coincides exactly with the READ state.
        enable_rd_d = (state_d == ST_READ);
    end

    assign enable_rd = enable_rd_q;
    assign expected  = expected_q;
    assign err_count = err_count_q;
    assign rd_count  = rd_count_q;
    assign err_flag  = err_flag_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Scoreboard bench for fifo_rd_checker: a FIFO model answers reads and a
// sequence-checker model predicts the outputs after every checked word.
module tb_fifo_rd_checker;
    localparam int DW = 3;
    localparam int PW = 2;
    localparam int EW = 8;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          enable_chk;
    logic [DW-1:0] data_in;
    logic          f_empty;
    logic          enable_rd;
    logic [DW-1:0] expected;
    logic [EW-1:0] err_count;
    logic [7:0]    rd_count;
    logic          err_flag;
    logic [1:0]    state;

    fifo_rd_checker #(.DATA_W(DW), .PRESCALE_W(PW), .ERR_W(EW)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .enable_chk(enable_chk),
        .data_in(data_in), .f_empty(f_empty), .enable_rd(enable_rd),
        .expected(expected), .err_count(err_count), .rd_count(rd_count),
        .err_flag(err_flag), .state(state)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int exp_v;
        int err;
        int rd;
        int flag;
    } resp_t;

    resp_t sb[$];
    int    fifo[$];
    int    pulse_cyc[$];
    int    m_exp, m_err, m_rd, m_flag, m_sync;
    int    n_vec = 0;
    int    n_bad = 0;
    int    n_pulse = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_exp = 0; m_err = 0; m_rd = 0; m_flag = 0; m_sync = 1;
    endtask

    task automatic model_word(input int w);
        resp_t r;
        if (m_sync != 0) begin
            m_exp  = (w + 1) % (1 << DW);
            m_sync = 0;
        end else if (w == m_exp) begin
            m_exp = (m_exp + 1) % (1 << DW);
        end else begin
            if (m_err < (1 << EW) - 1) m_err++;
            m_flag = 1;
            m_exp  = (w + 1) % (1 << DW);
        end
        m_rd = (m_rd + 1) % 256;
        r.exp_v = m_exp; r.err = m_err; r.rd = m_rd; r.flag = m_flag;
        sb.push_back(r);
    endtask

    task automatic push_word(input int w);
        fifo.push_back(w);
        f_empty = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int n = 0;
        while (n_pulse < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        wait_cycles(4);
        check(name, n_pulse, target);
    endtask

    task automatic wait_read(input int budget, input string name);
        int n = 0;
        while (enable_rd !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check(name, int'(enable_rd), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},     state,     0);
        check({tag, "_enable_rd"}, enable_rd, 0);
        check({tag, "_expected"},  expected,  0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_rd_count"},  rd_count,  0);
        check({tag, "_err_flag"},  err_flag,  0);
    endtask

    // FIFO responder: read data appears the cycle after enable_rd.
    initial begin
        int w;
        forever begin
            @(negedge clk_in);
            if (enable_rd === 1'b1) begin
                @(posedge clk_in);
                #1;
                if (reset_n) begin
                    if (fifo.size() == 0) begin
                        check("read_while_empty", 1, 0);
                    end else begin
                        w = fifo.pop_front();
                        data_in = DW'(w);
                        f_empty = (fifo.size() == 0);
                        model_word(w);
                    end
                end
                @(posedge clk_in);
                #1;
                data_in = DW'($urandom_range(0, (1 << DW) - 1));
            end
        end
    end

    // Monitor: each read pulse leads to one CHECK whose results are compared.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk_in);
            if (enable_rd === 1'b1) begin
                n_pulse++;
                pulse_cyc.push_back(cyc);
                if (reset_n) check("rd_in_read_state", state, 2);
                @(posedge clk_in);
                #1;
                if (reset_n) begin
                    check("rd_one_cycle", enable_rd, 0);
                    check("check_after_read", state, 3);
                end
                @(posedge clk_in);
                #1;
                if (reset_n) begin
                    if (sb.size() == 0) begin
                        check("sb_has_entry", 0, 1);
                    end else begin
                        r = sb.pop_front();
                        check("sb_expected",  expected,  r.exp_v);
                        check("sb_err_count", err_count, r.err);
                        check("sb_rd_count",  rd_count,  r.rd);
                        check("sb_err_flag",  err_flag,  r.flag);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, got cycle %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c, p, exp_cyc, base, v, e0;
        reset_n = 1'b0; enable_chk = 1'b0; f_empty = 1'b1; data_in = '0;
        model_reset();
        #1;
        check_reset_vals("por");
        wait_cycles(3);

        // 0..7 then 0..3, continuous enable
        for (int i = 0; i < 8; i++) push_word(i);
        for (int i = 0; i < 4; i++) push_word(i);
        enable_chk = 1'b1;
        m_sync = 1;
        reset_n = 1'b1;
        @(posedge clk_in); #1;
        check("rst_sync_edge1", state, 0);
        k = 0;
        while (state == 2'b00 && k < 4) begin
            @(posedge clk_in); #1;
            k++;
        end
        check("leave_idle", state, 1);
        wait_pulses(12, 200, "p1_pulses");
        for (int i = 1; i < 12; i++) check("p1_gap", pulse_cyc[i] - pulse_cyc[i-1], 4);
        check("p1_rd_count", rd_count, 12);
        check("p1_err_count", err_count, 0);
        check("p1_expected", expected, 4);
        check("p1_err_flag", err_flag, 0);

        // Empty for 3+ ticks, then one word: read on the first tick after
        wait_cycles(12);
        check("p2_no_read_empty", n_pulse, 12);
        c = cyc;
        p = pulse_cyc[11];
        exp_cyc = p + 4 * ((c + 1 - p + 3) / 4);
        push_word(2);
        wait_pulses(13, 40, "p2_pulses");
        check("p2_read_cycle", pulse_cyc[12], exp_cyc);
        check("p2_err_count", err_count, 1);

        // Resync sequence 5,6,0,1 after re-enable
        enable_chk = 1'b0;
        wait_cycles(8);
        check("dis_idle", state, 0);
        enable_chk = 1'b1;
        m_sync = 1;
        push_word(5); push_word(6); push_word(0); push_word(1);
        wait_pulses(17, 100, "p35_pulses");
        check("p35_expected", expected, 2);
        check("p35_err_count", err_count, 2);
        check("p35_err_flag", err_flag, 1);
        check("p35_rd_count", rd_count, 17);

        // Random mostly-incrementing stream with empty gaps
        v = $urandom_range(0, 7);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 7);
            push_word(v);
            v = (v + 1) % 8;
            wait_cycles($urandom_range(0, 6));
        end
        wait_pulses(57, 600, "rand_pulses");

        // Drop enable during READ
        push_word(m_exp);
        wait_read(40, "p38_read_seen");
        enable_chk = 1'b0;
        @(posedge clk_in); #1;
        check("p38_check", state, 3);
        @(posedge clk_in); #1;
        check("p38_idle", state, 0);
        wait_cycles(6);
        check("p38_no_more_reads", n_pulse, 58);
        e0 = m_err;
        enable_chk = 1'b1;
        m_sync = 1;
        push_word((m_exp + 3) % 8);
        wait_pulses(59, 40, "p38_pulses");
        check("p38_resync_no_err", err_count, e0);

        // Reset pulse during READ
        push_word(1);
        wait_read(40, "p39_read_seen");
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_read");
        fifo.delete();
        f_empty = 1'b1;
        sb.delete();
        model_reset();
        wait_cycles(3);
        check_reset_vals("rst_held");
        base = n_pulse;

        // Saturation: 300 identical words
        for (int i = 0; i < 300; i++) push_word(5);
        reset_n = 1'b1;
        wait_pulses(base + 300, 1500, "p37_pulses");
        check("p37_err_count", err_count, 255);
        check("p37_rd_count", rd_count, 44);
        check("p37_err_flag", err_flag, 1);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
